// File: rtl/fmult_pipe.sv
// Three-stage floating-point predictor multiplier: converts a 16-bit coefficient to
// float, multiplies by an 11-bit float sample, and denormalises to a 16-bit product.
module fmult_pipe #(
  parameter int unsigned NTERMS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] an,
  input  logic [10:0] sr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] wn,
  output logic [2:0]  out_idx,
  output logic        out_last,
  input  logic        scan_in0,
  input  logic        scan_en,
  output logic        scan_out0
);

  localparam logic [2:0] TagMax = 3'(NTERMS - 1);

  // All stages advance together; a full, blocked S3 freezes the whole pipe.
  logic adv;
  logic in_fire;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = reset && adv;
  assign in_fire  = in_valid && in_ready;

  assign scan_out0 = scan_en && scan_in0;

  logic [2:0] tag_q;

  // S1: coefficient to sign / exponent / 6-bit mantissa
  logic [13:0] an_shr;
  logic [12:0] an_mag;
  logic [3:0]  an_exp;
  logic [5:0]  an_mant;

  always_comb begin
    an_shr = an[15:2];
    an_mag = an[15] ? 13'(~an_shr + 14'd1) : an_shr[12:0];
    an_exp = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (an_mag[i]) an_exp = 4'(i + 1);
    end
    an_mant = (an_mag == 13'd0) ? 6'd32 : 6'(({an_mag, 6'b0}) >> an_exp);
  end

  logic        s1_valid_q;
  logic        s1_ans_q;
  logic [3:0]  s1_exp_q;
  logic [5:0]  s1_mant_q;
  logic [10:0] s1_sr_q;
  logic [2:0]  s1_tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q      <= 3'd0;
      s1_valid_q <= 1'b0;
      s1_ans_q   <= 1'b0;
      s1_exp_q   <= 4'd0;
      s1_mant_q  <= 6'd0;
      s1_sr_q    <= 11'd0;
      s1_tag_q   <= 3'd0;
    end else if (adv) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_ans_q  <= an[15];
        s1_exp_q  <= an_exp;
        s1_mant_q <= an_mant;
        s1_sr_q   <= sr;
        s1_tag_q  <= tag_q;
        tag_q     <= (tag_q == TagMax) ? 3'd0 : tag_q + 3'd1;
      end
    end
  end

  // S2: sign, exponent sum and rounded mantissa product
  logic [11:0] w_prod;
  logic [7:0]  w_mant;
  logic [4:0]  w_exp;
  logic        w_sign;

  always_comb begin
    w_prod = {6'b0, s1_mant_q} * {6'b0, s1_sr_q[5:0]};
    w_mant = 8'((w_prod + 12'd48) >> 4);
    w_exp  = {1'b0, s1_exp_q} + {1'b0, s1_sr_q[9:6]};
    w_sign = s1_ans_q ^ s1_sr_q[10];
  end

  logic       s2_valid_q;
  logic       s2_ws_q;
  logic [4:0] s2_exp_q;
  logic [7:0] s2_mant_q;
  logic [2:0] s2_tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_ws_q    <= 1'b0;
      s2_exp_q   <= 5'd0;
      s2_mant_q  <= 8'd0;
      s2_tag_q   <= 3'd0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ws_q   <= w_sign;
        s2_exp_q  <= w_exp;
        s2_mant_q <= w_mant;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  // S3: denormalise around exponent 26 and apply sign
  logic [14:0] w_mag;
  logic [15:0] w_val;

  always_comb begin
    if (s2_exp_q > 5'd26) begin
      w_mag = 15'({7'b0, s2_mant_q} << (s2_exp_q - 5'd26));
    end else begin
      w_mag = 15'({7'b0, s2_mant_q} >> (5'd26 - s2_exp_q));
    end
    // Negating zero yields zero, so no negative zero can appear.
    w_val = s2_ws_q ? (~{1'b0, w_mag} + 16'd1) : {1'b0, w_mag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      wn        <= 16'd0;
      out_idx   <= 3'd0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        wn       <= w_val;
        out_idx  <= s2_tag_q;
        out_last <= (s2_tag_q == TagMax);
      end
    end
  end

endmodule

// File: tb/tb_fmult_pipe.sv
// Self-checking bench for fmult_pipe: directed vectors plus randomized traffic checked
// against an arithmetic reference model and an expected-output queue.
module tb_fmult_pipe;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] an;
  logic [10:0] sr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wn;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        scan_in0;
  logic        scan_en;
  logic        scan_out0;

  fmult_pipe #(.NTERMS(NT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .an        (an),
    .sr        (sr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wn        (wn),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] wn;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tag_m = 0;
  int   n_out = 0;
  int   first_out_cyc = 0;
  int   last_out_cyc = 0;
  int   stall_from = -1;
  int   stall_len = 0;
  bit   rand_ready = 0;
  bit   saw_block = 0;
  bit   accepted;
  logic [15:0] cur_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic following the product definition.
  function automatic logic [15:0] ref_wn(input logic [15:0] a_in, input logic [10:0] s_in);
    int a, mag, e, mant, ws, wexp, wmant, wmag, res;
    a    = int'(a_in);
    mag  = a_in[15] ? ((-(a >> 2)) & 'h1FFF) : (a >> 2);
    e    = 0;
    while ((1 << e) <= mag) e++;
    mant  = (mag == 0) ? 32 : (((mag << 6) >> e) & 63);
    ws    = int'(a_in[15] ^ s_in[10]);
    wexp  = e + int'(s_in[9:6]);
    wmant = (mant * int'(s_in[5:0]) + 48) >> 4;
    wmag  = (wexp > 26) ? ((wmant << (wexp - 26)) & 'h7FFF) : (wmant >> (26 - wexp));
    res   = ws ? ((-wmag) & 'hFFFF) : wmag;
    return 16'(res);
  endfunction

  // One clock: settle, score transfers, advance to just after the next edge.
  task automatic step();
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
    else if (stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len) out_ready = 0;
    else out_ready = 1;
    #1;
    if (in_valid && !in_ready) saw_block = 1;
    if (in_valid && in_ready) begin
      q.push_back('{wn: cur_exp, idx: tag_m});
      tag_m    = (tag_m == NT - 1) ? 0 : tag_m + 1;
      accepted = 1;
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("wn", 32'(wn), 32'(q[0].wn));
        check("out_idx", 32'(out_idx), 32'(q[0].idx));
        check("out_last", 32'(out_last), 32'(q[0].idx == NT - 1));
        if (out_ready) begin
          void'(q.pop_front());
          if (n_out == 0) first_out_cyc = cyc;
          n_out++;
          last_out_cyc = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] a_v, input logic [10:0] s_v, input logic [15:0] e_v);
    an       = a_v;
    sr       = s_v;
    cur_exp  = e_v;
    in_valid = 1;
    accepted = 0;
    for (int k = 0; k < 50 && !accepted; k++) step();
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) step();
  endtask

  task automatic drain();
    in_valid = 0;
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    reset    = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    tag_m = 0;
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    n_out = 0;
  endtask

  initial begin
    int lat;
    reset     = 0;
    in_valid  = 0;
    an        = '0;
    sr        = '0;
    out_ready = 1;
    scan_in0  = 1;
    scan_en   = 0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_wn", 32'(wn), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("scan_inert", 32'(scan_out0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Zero coefficient and latency measured from the transfer cycle.
    send(16'h0000, 11'h020, 16'h0000);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    send(16'h4000, 11'h2E0, 16'h0010);
    send(16'hC000, 11'h2E0, 16'hFFF0);
    send(16'h4000, 11'h3FF, 16'h0204);
    send(16'hC000, 11'h020, 16'h0000);
    send(16'h8000, 11'h7C0, ref_wn(16'h8000, 11'h7C0));
    send(16'hFFFF, 11'h5C0, ref_wn(16'hFFFF, 11'h5C0));
    send(16'h1234, 11'h3C0, ref_wn(16'h1234, 11'h3C0));
    drain();

    // Back-to-back frames with the sink always ready.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a_r;
      logic [10:0] s_r;
      a_r = 16'($urandom);
      s_r = 11'($urandom);
      send(a_r, s_r, ref_wn(a_r, s_r));
    end
    drain();
    check("b2b_count", 32'(n_out), 32'd16);
    check("b2b_span", 32'(last_out_cyc - first_out_cyc), 32'd15);

    // Sink stalls for 5 cycles mid-stream.
    do_reset();
    saw_block  = 0;
    stall_from = cyc + 6;
    stall_len  = 5;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a_r;
      logic [10:0] s_r;
      a_r = 16'($urandom);
      s_r = 11'($urandom);
      send(a_r, s_r, ref_wn(a_r, s_r));
    end
    drain();
    stall_len = 0;
    check("stall_count", 32'(n_out), 32'd20);
    check("stall_in_ready_low", 32'(saw_block), 32'd1);

    // Reset with products in flight.
    do_reset();
    send(16'h4000, 11'h2E0, 16'h0010);
    send(16'h2000, 11'h2E0, ref_wn(16'h2000, 11'h2E0));
    send(16'h6000, 11'h2E0, ref_wn(16'h6000, 11'h2E0));
    in_valid = 0;
    reset    = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    tag_m = 0;
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    n_out = 0;
    send(16'hC000, 11'h2E0, 16'hFFF0);
    drain();
    check("midrst_count", 32'(n_out), 32'd1);

    // Random traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a_r;
      logic [10:0] s_r;
      a_r = 16'($urandom);
      s_r = 11'($urandom);
      if ($urandom_range(4) == 0) s_r[5:0] = 6'd0;
      send(a_r, s_r, ref_wn(a_r, s_r));
      if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
    end
    rand_ready = 0;
    drain();

    scan_en = 1;
    #1;
    check("scan_en_path", 32'(scan_out0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/fmult_pipe.md
FMULT_PIPE -- requirements
Module: fmult_pipe

Interface
REQ-001 SHALL provide parameter NTERMS, default 8, meaning products per predictor frame (6 zero + 2 pole terms feeding the accumulator stage).
REQ-002 SHALL provide port clk  input  1  rising-edge clock, only clock in the block.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  operand pair present.
REQ-005 SHALL provide port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL provide port an  input  16  predictor coefficient An/Bn, two's complement.
REQ-007 SHALL provide port sr  input  11  reconstructed-signal float: [10] sign, [9:6] exp, [5:0] mantissa.
REQ-008 SHALL provide port out_valid  output  1  product wn valid.
REQ-009 SHALL provide port out_ready  input  1  downstream accumulator accepts wn.
REQ-010 SHALL provide port wn  output  16  signed partial product WAn/WBn, two's complement.
REQ-011 SHALL provide port out_idx  output  3  term index 0..NTERMS-1 within frame.
REQ-012 SHALL provide port out_last  output  1  high with the product whose out_idx = NTERMS-1.
REQ-013 SHALL provide ports scan_in0/scan_en  input  1 and scan_out0  output  1, scan hooks, functionally inert when scan_en=0.

Function
REQ-014 SHALL transfer an input when in_valid & in_ready, an output when out_valid & out_ready, both on clk rising edge.
REQ-015 SHALL implement a 3-stage pipeline (S1 convert, S2 multiply, S3 denormalise); latency from input transfer to out_valid = 3 cycles with no stall.
REQ-016 SHALL sustain one transfer per cycle when out_ready stays high.
REQ-017 SHALL stall all stages when out_valid & !out_ready; in_ready = !(S3 full & !out_ready) with bubble collapse allowed in S1/S2; no data lost or duplicated.
REQ-018 S1: ans = an[15]; anmag = ans ? (-(an>>2 logical)) & 0x1FFF : an>>2; anexp = bit-length of anmag (0..13); anmant = (anmag==0) ? 32 : (anmag<<6)>>anexp, 6 bits.
REQ-019 S2: ws = ans ^ sr[10]; wexp = anexp + sr[9:6] (5 bits, 0..28); wmant = (anmant*sr[5:0] + 48) >> 4, 8 bits.
REQ-020 S3: wmag = wexp>26 ? (wmant<<(wexp-26)) & 0x7FFF : wmant>>(26-wexp); wn = ws ? (-wmag)&0xFFFF : wmag.
REQ-021 SHALL register wn, out_idx, out_last; outputs stable while out_valid & !out_ready.
REQ-022 SHALL tag each accepted input with a 3-bit counter value; counter increments per input transfer, wraps from NTERMS-1 to 0.
REQ-023 Magnitude zero with ws=1 SHALL produce wn=0x0000 (no negative zero).
REQ-024 Mantissa sr[5:0]=0 SHALL be computed per formula, no special casing.

Reset
REQ-025 On reset low, asynchronously: out_valid=0, wn=0, out_idx=0, out_last=0, all stage valid flags=0, tag counter=0.
REQ-026 in_ready SHALL be 0 while reset is low and 1 in the first cycle after release.
REQ-027 Reset mid-frame SHALL discard all in-flight products; next accepted input is tagged 0.

Verification
REQ-028 an=0x0000, sr=0x020 -> wn=0x0000, out_idx=0, out_valid exactly 3 cycles after transfer.
REQ-029 an=0x4000, sr=0x2E0 (exp 11, mant 32) -> wn=0x0010; an=0xC000 same sr -> wn=0xFFF0.
REQ-030 an=0x4000, sr=0x3FF (sign 0, exp 15, mant 63) -> wn=0x0204 (left-shift path).
REQ-031 16 back-to-back inputs, out_ready=1 -> 16 outputs on consecutive cycles, out_idx 0..7,0..7, out_last on 8th and 16th.
REQ-032 out_ready low 5 cycles mid-stream -> in_ready drops once pipeline full, wn/out_idx held, order and count preserved after release.
REQ-033 reset asserted with 3 products in flight -> out_valid=0 immediately; after release first output has out_idx=0.
